// File: rtl/avmm_row_loader.sv
//==============================================================================
// avmm_row_loader : reads NUM_ROWS+1 64-bit words over Avalon-MM and streams
// their bytes MSB-first into the A FIFOs (one word each) and the B FIFO.
// Optional macro ROW_LOADER_PERF_CNT_EN adds a saturating busy-cycle counter.
// Revision: 1.0
//==============================================================================
`default_nettype none

module avmm_row_loader #(
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_ROWS   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           avm_address,
  output logic                  avm_read,
  input  logic [63:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic [NUM_ROWS-1:0]   fifo_a_wren,
  output logic                  fifo_b_wren,
  output logic [DATA_WIDTH-1:0] fifo_wrdata,
  input  logic [NUM_ROWS-1:0]   fifo_a_full,
  input  logic                  fifo_b_full,
  output logic [15:0]           perf_cycles
);

  localparam int                   c_word_bits = $clog2(NUM_ROWS + 1);
  localparam logic [c_word_bits-1:0] c_last_word = c_word_bits'(NUM_ROWS);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_word_bits-1:0] r_word, w_word_nxt;
  logic [2:0]             r_byte, w_byte_nxt, w_byte_inc;
  logic [63:0]            r_hold, w_hold_nxt;
  logic [DATA_WIDTH-1:0]  w_wrdata_nxt;
  logic [NUM_ROWS-1:0]    w_a_sel;
  logic [5:0]             w_shift;
  logic                   w_read_nxt, w_issue, w_to_b, w_tgt_full, w_wrote;

  always_comb begin
    w_a_sel = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (r_word == c_word_bits'(i)) w_a_sel[i] = 1'b1;
  end

  assign w_to_b     = (r_word == c_last_word);
  assign w_tgt_full = w_to_b ? fifo_b_full : |(fifo_a_full & w_a_sel);
  assign w_wrote    = (|fifo_a_wren) | fifo_b_wren;
  assign w_byte_inc = r_byte + 3'd1;
  // Bit offset of the next byte, counting down from the MSB byte.
  assign w_shift    = {~w_byte_inc, 3'b000};

  // The write-enable register shows whether the byte now on fifo_wrdata is
  // being written this cycle; r_byte only advances once that has happened.
  always_comb begin
    w_state_nxt  = r_state;
    w_word_nxt   = r_word;
    w_byte_nxt   = r_byte;
    w_hold_nxt   = r_hold;
    w_wrdata_nxt = fifo_wrdata;
    w_read_nxt   = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = FETCH;
          w_word_nxt  = '0;
          w_read_nxt  = 1'b1;
        end
      end
      FETCH: begin
        if (avm_waitrequest) w_read_nxt = 1'b1;
        else                 w_state_nxt = WAIT;
      end
      WAIT: begin
        if (avm_readdatavalid) begin
          w_state_nxt  = WRITE;
          w_hold_nxt   = avm_readdata;
          w_byte_nxt   = '0;
          w_wrdata_nxt = DATA_WIDTH'(avm_readdata[63:56]);
          w_issue      = !w_tgt_full;
        end
      end
      WRITE: begin
        if (!w_wrote) begin
          w_issue = !w_tgt_full;
        end else if (r_byte == 3'd7) begin
          if (w_to_b) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = FETCH;
            w_word_nxt  = r_word + c_word_bits'(1);
            w_read_nxt  = 1'b1;
          end
        end else begin
          w_byte_nxt   = w_byte_inc;
          w_wrdata_nxt = DATA_WIDTH'(r_hold[w_shift +: 8]);
          w_issue      = !w_tgt_full;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_byte      <= '0;
      r_hold      <= '0;
      avm_read    <= 1'b0;
      avm_address <= BASE_ADDR;
      fifo_a_wren <= '0;
      fifo_b_wren <= 1'b0;
      fifo_wrdata <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word      <= w_word_nxt;
      r_byte      <= w_byte_nxt;
      r_hold      <= w_hold_nxt;
      avm_read    <= w_read_nxt;
      avm_address <= BASE_ADDR + 32'(w_word_nxt);
      fifo_a_wren <= (w_issue && !w_to_b) ? w_a_sel : '0;
      fifo_b_wren <= w_issue && w_to_b;
      fifo_wrdata <= w_wrdata_nxt;
      busy        <= (w_state_nxt == FETCH) || (w_state_nxt == WAIT) || (w_state_nxt == WRITE);
      done        <= (w_state_nxt == DONE);
    end
  end

`ifdef ROW_LOADER_PERF_CNT_EN
  logic        w_start_ok;
  logic [15:0] r_perf;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_perf <= '0;
    else if (w_start_ok)                  r_perf <= '0;
    else if (busy && r_perf != 16'hFFFF)  r_perf <= r_perf + 16'd1;
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_avmm_row_loader.sv
//==============================================================================
// tb_avmm_row_loader : directed loads against an expected-byte-stream model.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_avmm_row_loader;

  localparam int          NR   = 8;
  localparam int          DW   = 8;
  localparam int          TOT  = (NR + 1) * 8;
  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef ROW_LOADER_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk, rst, start, busy, done;
  logic [31:0]   avm_address;
  logic          avm_read, avm_readdatavalid, avm_waitrequest;
  logic [63:0]   avm_readdata;
  logic [NR-1:0] fifo_a_wren, fifo_a_full;
  logic          fifo_b_wren, fifo_b_full;
  logic [DW-1:0] fifo_wrdata;
  logic [15:0]   perf_cycles;

  avmm_row_loader #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .fifo_a_wren(fifo_a_wren), .fifo_b_wren(fifo_b_wren), .fifo_wrdata(fifo_wrdata),
    .fifo_a_full(fifo_a_full), .fifo_b_full(fifo_b_full), .perf_cycles(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct { int tgt; logic [7:0] data; } wr_t;
  wr_t         expq[$];
  logic [63:0] mem [0:NR];
  int          wstall [0:NR];
  int          rd_cycles [0:NR];
  int          wr_samp [0:TOT-1];
  bit          log_a0 [0:255];
  bit          log_b  [0:255];
  bit          log_rd [0:255];
  logic [7:0]  log_d  [0:255];
  bit          loading, finished, pend, trig_seen, trig_full;
  int          lat, pend_cnt, pend_word, samp, busy_cycles, full_left, full_word, trig_word;
  logic [7:0]  trig_byte;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_read"}, avm_read, 0);
    check({tag, "_addr"}, avm_address, BASE);
    check({tag, "_a_wren"}, fifo_a_wren, 0);
    check({tag, "_b_wren"}, fifo_b_wren, 0);
    check({tag, "_wrdata"}, fifo_wrdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_perf"}, perf_cycles, 0);
  endtask

  // Per-cycle comparison of the DUT against the expected write stream.
  task automatic compare();
    int  n_en, tgt, widx;
    wr_t e;
    check("busy", busy, loading);
    check("done", done, finished);
    n_en = $countones(fifo_a_wren) + int'(fifo_b_wren);
    check("wren_onehot", n_en <= 1, 1);
    if (samp < 256) begin
      log_a0[samp] = fifo_a_wren[0];
      log_b[samp]  = fifo_b_wren;
      log_rd[samp] = avm_read;
      log_d[samp]  = fifo_wrdata;
    end
    if (busy) busy_cycles++;
    if (!loading) begin
      check("wren_idle", n_en, 0);
      check("read_idle", avm_read, 0);
    end else begin
      if (n_en != 0) begin
        tgt = NR;
        for (int i = 0; i < NR; i++) if (fifo_a_wren[i]) tgt = i;
        check("wren_while_full", (|(fifo_a_wren & fifo_a_full)) | (fifo_b_wren & fifo_b_full), 0);
        widx = TOT - expq.size();
        e = expq.pop_front();
        wr_samp[widx] = samp;
        check("wr_target", tgt, e.tgt);
        check("wr_data", fifo_wrdata, e.data);
        if (e.tgt == trig_word && e.data == trig_byte) begin
          trig_seen = 1'b1;
          if (trig_full) full_left = 5;
        end
        if (expq.size() == 0) begin
          loading  = 1'b0;
          finished = 1'b1;
        end
      end
      if (avm_read) begin
        widx = NR + 1 - expq.size() / 8;
        check("avm_address", avm_address, BASE + 32'(widx));
        if (widx >= 0 && widx <= NR) rd_cycles[widx]++;
      end
    end
  endtask

  // Avalon slave with per-word waitrequest stalls and fixed read latency.
  task automatic drive();
    int w;
    start             = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = {$urandom, $urandom};
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem[pend_word];
        pend              = 1'b0;
      end
    end
    avm_waitrequest = 1'b0;
    if (avm_read) begin
      w = int'(avm_address - BASE);
      if (w < 0 || w > NR) w = 0;
      if (wstall[w] > 0) begin
        avm_waitrequest = 1'b1;
        wstall[w]--;
      end else begin
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_word = w;
      end
    end
    fifo_a_full = '0;
    fifo_b_full = 1'b0;
    if (full_left > 0) begin
      fifo_a_full[full_word] = 1'b1;
      full_left--;
    end
  endtask

  task automatic step();
    @(negedge clk);
    samp++;
    compare();
    drive();
  endtask

  task automatic do_start();
    wr_t e;
    start = 1'b1;
    if (!loading) begin
      expq.delete();
      for (int w = 0; w <= NR; w++)
        for (int k = 0; k < 8; k++) begin
          e.tgt  = w;
          e.data = mem[w][63-8*k -: 8];
          expq.push_back(e);
        end
      for (int w = 0; w <= NR; w++) rd_cycles[w] = 0;
      loading     = 1'b1;
      finished    = 1'b0;
      samp        = 0;
      busy_cycles = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!finished && n < budget) begin
      step();
      n++;
    end
    if (!finished) begin
      n_chk++;
      $display("FAIL timeout: done not reached within %0d cycles", budget);
      loading = 1'b0;
      expq.delete();
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    avm_waitrequest = 1'b0; fifo_a_full = '0; fifo_b_full = 1'b0;
    loading = 0; finished = 0; pend = 0; trig_seen = 0; trig_full = 0;
    lat = 1; full_left = 0; full_word = 0; trig_word = -1; trig_byte = 8'h00; samp = 0;
    for (int w = 0; w <= NR; w++) begin
      wstall[w] = 0;
      for (int k = 0; k < 8; k++) mem[w][63-8*k -: 8] = 8'(16 * w + k + 1);
    end

    step();
    check_reset_vals("reset");
    step();
    rst = 1'b0;
    step();
    check_reset_vals("post_reset");

    // Load A: L=1, no stalls; pins exact cycle positions.
    do_start();
    wait_done(300);
    check("A_busy_total", busy_cycles, 9 * (1 + 1 + 8));
    check("A_read_s1", log_rd[1], 1);
    check("A_read_s2", log_rd[2], 0);
    check("A_no_wren_s2", log_a0[2], 0);
    for (int s = 3; s <= 10; s++) begin
      check("A_w0_wren", log_a0[s], 1);
      check("A_w0_data", log_d[s], 8'(s - 2));
    end
    check("A_w0_end", log_a0[11], 0);
    check("A_b_first_en", log_b[83], 1);
    check("A_b_first_data", log_d[83], 8'h81);
    check("A_b_last_en", log_b[90], 1);
    check("A_b_last_data", log_d[90], 8'h88);
    check("A_perf", perf_cycles, PERF_EN ? 90 : 0);
    for (int w = 0; w <= NR; w++) check("A_read_cycles", rd_cycles[w], 1);

    // Load B: waitrequest held 3 cycles on word 4.
    wstall[4] = 3;
    do_start();
    wait_done(300);
    check("B_busy_total", busy_cycles, 93);
    check("B_word4_read_cycles", rd_cycles[4], 4);
    check("B_word5_read_cycles", rd_cycles[5], 1);

    // Load C: A FIFO 2 full for 5 cycles while byte 0x24 is pending.
    trig_word = 2; trig_byte = 8'h23; trig_full = 1'b1; full_word = 2; trig_seen = 1'b0;
    do_start();
    wait_done(300);
    check("C_busy_total", busy_cycles, 95);
    check("C_stall_gap", wr_samp[19] - wr_samp[18], 6);
    check("C_resume_gap", wr_samp[20] - wr_samp[19], 1);
    trig_full = 1'b0;

    // Load D: reset in the middle of word 5, then a stray read response.
    trig_word = 5; trig_byte = 8'h53; trig_seen = 1'b0;
    do_start();
    n = 0;
    while (!trig_seen && n < 300) begin
      step();
      n++;
    end
    check("D_reached_word5", trig_seen, 1);
    rst = 1'b1;
    expq.delete();
    loading = 0; finished = 0; pend = 0; full_left = 0;
    #1;
    check_reset_vals("D_rst_async");
    step();
    check_reset_vals("D_rst_held");
    rst = 1'b0;
    step();
    avm_readdatavalid = 1'b1;
    avm_readdata      = 64'hA1A2_A3A4_A5A6_A7A8;
    for (int i = 0; i < 4; i++) begin
      step();
      check_reset_vals("D_after");
    end
    trig_word = -1;

    // Load E: L=2 with a start pulse while busy.
    lat = 2;
    do_start();
    for (int i = 0; i < 40; i++) step();
    do_start();
    wait_done(400);
    check("E_busy_total", busy_cycles, 99);
    check("E_perf_done", perf_cycles, PERF_EN ? 99 : 0);
    for (int i = 0; i < 3; i++) step();
    check("E_perf_hold", perf_cycles, PERF_EN ? 99 : 0);
    check("E_done_hold", done, 1);
    do_start();
    step();
    check("E_perf_clear", perf_cycles, 0);
    step();
    check("E_perf_count", perf_cycles, PERF_EN ? 1 : 0);
    wait_done(400);
    check("E2_busy_total", busy_cycles, 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
